// File: rtl/multi_led_blinker.sv
// N-channel switch-to-LED controller: each debounced press cycles its channel
// through OFF, ON, slow blink and fast blink, using one shared blink timebase.
module multi_led_blinker #(
   parameter int CHANNELS        = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int FAST_HALF       = 3,
   parameter int SLOW_DIV        = 2,
   parameter bit LED_ACTIVE_LOW  = 1'b0
) (
   input  logic                  CLOCK,
   input  logic                  RESET_N,
   input  logic [CHANNELS-1:0]   switch_n,
   output logic [CHANNELS-1:0]   led,
   output logic [2*CHANNELS-1:0] mode
);

   typedef enum logic [1:0] {
      MODE_OFF  = 2'b00,
      MODE_ON   = 2'b01,
      MODE_SLOW = 2'b10,
      MODE_FAST = 2'b11
   } mode_t;

   localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
   localparam int PRE_W  = (FAST_HALF > 1) ? $clog2(FAST_HALF) : 1;
   localparam int SLOW_W = $clog2(SLOW_DIV);

   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(FAST_HALF - 1);
   localparam logic [SLOW_W-1:0] SLOW_LAST = SLOW_W'(SLOW_DIV - 1);

   logic [PRE_W-1:0]  prescaler;
   logic [SLOW_W-1:0] slow_cnt;
   logic              fast_phase;
   logic              slow_phase;
   logic              fast_wrap;
   logic              slow_wrap;

   assign fast_wrap = (prescaler == PRE_LAST);
   assign slow_wrap = fast_wrap && (slow_cnt == SLOW_LAST);

   // One free-running timebase keeps all channels in the same blink mode in phase.
   always_ff @(posedge CLOCK) begin
      if (!RESET_N) begin
         prescaler  <= '0;
         slow_cnt   <= '0;
         fast_phase <= 1'b0;
         slow_phase <= 1'b0;
      end else if (fast_wrap) begin
         prescaler  <= '0;
         fast_phase <= ~fast_phase;
         if (slow_wrap) begin
            slow_cnt   <= '0;
            slow_phase <= ~slow_phase;
         end else begin
            slow_cnt <= slow_cnt + SLOW_W'(1);
         end
      end else begin
         prescaler <= prescaler + PRE_W'(1);
      end
   end

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic             sync1;
      logic             sync2;
      logic             deb;
      logic [DEB_W-1:0] deb_cnt;
      logic             press;
      logic             led_q;
      mode_t            state;

      // A press is the edge on which the debounced level accepts a low.
      assign press = deb && !sync2 && (deb_cnt == DEB_LAST);

      always_ff @(posedge CLOCK) begin
         if (!RESET_N) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            deb     <= 1'b1;
            deb_cnt <= '0;
            state   <= MODE_OFF;
            led_q   <= LED_ACTIVE_LOW;
         end else begin
            sync1 <= switch_n[gi];
            sync2 <= sync1;

            if (sync2 == deb) begin
               deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
               deb     <= sync2;
               deb_cnt <= '0;
            end else begin
               deb_cnt <= deb_cnt + DEB_W'(1);
            end

            if (press) begin
               case (state)
                  MODE_OFF:  state <= MODE_ON;
                  MODE_ON:   state <= MODE_SLOW;
                  MODE_SLOW: state <= MODE_FAST;
                  MODE_FAST: state <= MODE_OFF;
               endcase
            end

            // LED follows the mode held before this edge, so it lags a mode change by one edge.
            case (state)
               MODE_OFF:  led_q <= LED_ACTIVE_LOW;
               MODE_ON:   led_q <= ~LED_ACTIVE_LOW;
               MODE_SLOW: led_q <= slow_phase ^ LED_ACTIVE_LOW;
               MODE_FAST: led_q <= fast_phase ^ LED_ACTIVE_LOW;
            endcase
         end
      end

      assign led[gi]          = led_q;
      assign mode[2*gi +: 2]  = state;
   end

endmodule

// File: tb/tb_multi_led_blinker.sv
// Self-checking bench for multi_led_blinker: directed scenarios plus random switch
// activity, compared against a history-based behavioural model.
module tb_multi_led_blinker;

   localparam int CH = 2;
   localparam int DC = 4;
   localparam int FH = 3;
   localparam int SD = 2;

   logic        CLOCK    = 1'b0;
   logic        RESET_N  = 1'b0;
   logic [1:0]  switch_n = 2'b11;
   logic [1:0]  led;
   logic [1:0]  led_al;
   logic [3:0]  mode;
   logic [3:0]  mode_al;

   int assert_cnt = 0;
   int fail_cnt   = 0;

   multi_led_blinker #(
      .CHANNELS(CH), .DEBOUNCE_CYCLES(DC), .FAST_HALF(FH), .SLOW_DIV(SD), .LED_ACTIVE_LOW(1'b0)
   ) dut (
      .CLOCK(CLOCK), .RESET_N(RESET_N), .switch_n(switch_n), .led(led), .mode(mode)
   );

   multi_led_blinker #(
      .CHANNELS(CH), .DEBOUNCE_CYCLES(DC), .FAST_HALF(FH), .SLOW_DIV(SD), .LED_ACTIVE_LOW(1'b1)
   ) dut_al (
      .CLOCK(CLOCK), .RESET_N(RESET_N), .switch_n(switch_n), .led(led_al), .mode(mode_al)
   );

   always #5 CLOCK = ~CLOCK;

   // Reference model: a level is accepted once the last DC samples seen through the
   // two-edge synchroniser all disagree with it; blink phases come from the edge count.
   bit hist [CH][$];
   bit m_deb  [CH];
   bit m_led  [CH];
   int m_mode [CH];
   int m_n;

   always @(posedge CLOCK) begin
      if (!RESET_N) begin
         for (int c = 0; c < CH; c++) begin
            hist[c].delete();
            for (int k = 0; k < DC + 2; k++) hist[c].push_back(1'b1);
            m_deb[c]  = 1'b1;
            m_mode[c] = 0;
            m_led[c]  = 1'b0;
         end
         m_n = 0;
      end else begin
         for (int c = 0; c < CH; c++) begin
            bit all_diff;
            case (m_mode[c])
               0:       m_led[c] = 1'b0;
               1:       m_led[c] = 1'b1;
               2:       m_led[c] = bit'((m_n / (FH * SD)) % 2);
               default: m_led[c] = bit'((m_n / FH) % 2);
            endcase
            hist[c].push_back(switch_n[c]);
            void'(hist[c].pop_front());
            all_diff = 1'b1;
            for (int k = 0; k < DC; k++) if (hist[c][k] == m_deb[c]) all_diff = 1'b0;
            if (all_diff) begin
               m_deb[c] = !m_deb[c];
               if (!m_deb[c]) m_mode[c] = (m_mode[c] + 1) % 4;
            end
         end
         m_n++;
      end
   end

   function automatic logic [3:0] exp_mode_vec();
      logic [3:0] v;
      v = '0;
      for (int i = 0; i < CH; i++) v[2*i +: 2] = 2'(m_mode[i]);
      return v;
   endfunction

   function automatic logic [1:0] exp_led_vec();
      logic [1:0] v;
      v = '0;
      for (int i = 0; i < CH; i++) v[i] = m_led[i];
      return v;
   endfunction

   task automatic tick();
      @(posedge CLOCK);
      @(negedge CLOCK);
   endtask

   task automatic do_reset();
      RESET_N  = 1'b0;
      switch_n = 2'b11;
      tick();
      RESET_N  = 1'b1;
   endtask

   task automatic test_reset();
      RESET_N  = 1'b0;
      switch_n = 2'b11;
      tick();
      tick();
      assert_cnt++;
      if (mode !== 4'b0000) begin
         fail_cnt++;
         $display("[TB] FAIL reset_mode: got %b, want 0000", mode);
      end
      assert_cnt++;
      if (led !== 2'b00) begin
         fail_cnt++;
         $display("[TB] FAIL reset_led: got %b, want 00", led);
      end
      assert_cnt++;
      if (led_al !== 2'b11 || mode_al !== 4'b0000) begin
         fail_cnt++;
         $display("[TB] FAIL reset_active_low: led %b mode %b, want 11 0000", led_al, mode_al);
      end
      RESET_N = 1'b1;
   endtask

   task automatic test_clean_press();
      do_reset();
      switch_n = 2'b10;
      for (int e = 1; e <= 7; e++) begin
         tick();
         assert_cnt++;
         if (mode !== exp_mode_vec() || led !== exp_led_vec() || led_al !== ~exp_led_vec()) begin
            fail_cnt++;
            $display("[TB] FAIL press_model edge %0d: mode %b led %b, want %b %b", e, mode, led, exp_mode_vec(), exp_led_vec());
         end
         if (e == 5) begin
            assert_cnt++;
            if (mode[1:0] !== 2'b00) begin
               fail_cnt++;
               $display("[TB] FAIL press_early: mode %b at edge 5, want 00", mode[1:0]);
            end
         end
         if (e == 6) begin
            assert_cnt++;
            if (mode !== 4'b0001 || led[0] !== 1'b0) begin
               fail_cnt++;
               $display("[TB] FAIL press_edge6: mode %b led0 %b, want 0001 0", mode, led[0]);
            end
         end
         if (e == 7) begin
            assert_cnt++;
            if (led !== 2'b01 || led_al !== 2'b10) begin
               fail_cnt++;
               $display("[TB] FAIL press_led: led %b led_al %b, want 01 10", led, led_al);
            end
         end
      end
      switch_n = 2'b11;
      repeat (8) tick();
   endtask

   task automatic test_bounce();
      logic pattern [8];
      pattern = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      do_reset();
      for (int i = 0; i < 16; i++) begin
         switch_n[0] = (i < 8) ? pattern[i] : 1'b1;
         tick();
         assert_cnt++;
         if (mode !== 4'b0000 || led !== 2'b00 || mode !== exp_mode_vec()) begin
            fail_cnt++;
            $display("[TB] FAIL bounce step %0d: mode %b led %b, want 0000 00", i, mode, led);
         end
      end
   endtask

   task automatic test_cycling();
      int exp_seq [4] = '{1, 2, 3, 0};
      int exp_tog [4] = '{0, 2, 4, 0};
      do_reset();
      for (int p = 0; p < 4; p++) begin
         int   toggles;
         logic prev;
         switch_n[0] = 1'b0;
         repeat (8) tick();
         assert_cnt++;
         if (mode[1:0] !== 2'(exp_seq[p]) || mode[3:2] !== 2'b00) begin
            fail_cnt++;
            $display("[TB] FAIL cycle_mode press %0d: got %b, want %0d", p, mode, exp_seq[p]);
         end
         switch_n[0] = 1'b1;
         repeat (8) tick();
         toggles = 0;
         prev    = led[0];
         for (int e = 0; e < 12; e++) begin
            tick();
            if (led[0] !== prev) toggles++;
            prev = led[0];
            assert_cnt++;
            if (mode !== exp_mode_vec() || led !== exp_led_vec() || led_al !== ~exp_led_vec()) begin
               fail_cnt++;
               $display("[TB] FAIL cycle_model press %0d edge %0d: mode %b led %b, want %b %b", p, e, mode, led, exp_mode_vec(), exp_led_vec());
            end
         end
         assert_cnt++;
         if (toggles != exp_tog[p]) begin
            fail_cnt++;
            $display("[TB] FAIL cycle_toggles press %0d: got %0d, want %0d", p, toggles, exp_tog[p]);
         end
      end
      assert_cnt++;
      if (led[0] !== 1'b0) begin
         fail_cnt++;
         $display("[TB] FAIL cycle_off_led: got %b, want 0", led[0]);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      switch_n = 2'b00;
      repeat (5) tick();
      assert_cnt++;
      if (mode !== 4'b0000) begin
         fail_cnt++;
         $display("[TB] FAIL simul_early: got %b, want 0000", mode);
      end
      tick();
      assert_cnt++;
      if (mode !== 4'b0101) begin
         fail_cnt++;
         $display("[TB] FAIL simul_press: got %b, want 0101", mode);
      end
      repeat (2) begin
         switch_n = 2'b11;
         repeat (8) tick();
         switch_n = 2'b00;
         repeat (8) tick();
      end
      switch_n = 2'b11;
      assert_cnt++;
      if (mode !== 4'b1111) begin
         fail_cnt++;
         $display("[TB] FAIL simul_fast: got %b, want 1111", mode);
      end
      for (int e = 0; e < 20; e++) begin
         tick();
         assert_cnt++;
         if (led[0] !== led[1] || led !== exp_led_vec() || led_al !== ~exp_led_vec()) begin
            fail_cnt++;
            $display("[TB] FAIL simul_phase edge %0d: led %b, want %b", e, led, exp_led_vec());
         end
      end
   endtask

   task automatic test_reset_mid_blink();
      do_reset();
      repeat (2) begin
         switch_n[0] = 1'b0;
         repeat (8) tick();
         switch_n[0] = 1'b1;
         repeat (8) tick();
      end
      switch_n[0] = 1'b0;
      repeat (8) tick();
      repeat (4) tick();
      assert_cnt++;
      if (mode[1:0] !== 2'b11) begin
         fail_cnt++;
         $display("[TB] FAIL midblink_setup: got %b, want 11", mode[1:0]);
      end
      RESET_N = 1'b0;
      tick();
      assert_cnt++;
      if (mode !== 4'b0000 || led !== 2'b00 || led_al !== 2'b11) begin
         fail_cnt++;
         $display("[TB] FAIL midblink_reset: mode %b led %b led_al %b, want 0000 00 11", mode, led, led_al);
      end
      RESET_N = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         tick();
         if (e == 1) begin
            assert_cnt++;
            if (led[0] !== 1'b0) begin
               fail_cnt++;
               $display("[TB] FAIL midblink_led: got %b, want 0", led[0]);
            end
         end
         if (e == 5) begin
            assert_cnt++;
            if (mode[1:0] !== 2'b00) begin
               fail_cnt++;
               $display("[TB] FAIL midblink_early: got %b, want 00", mode[1:0]);
            end
         end
         if (e == 6) begin
            assert_cnt++;
            if (mode[1:0] !== 2'b01 || mode !== exp_mode_vec()) begin
               fail_cnt++;
               $display("[TB] FAIL midblink_repress: got %b, want 01", mode[1:0]);
            end
         end
      end
      switch_n = 2'b11;
      repeat (8) tick();
   endtask

   task automatic test_random();
      int run_left [CH];
      do_reset();
      for (int c = 0; c < CH; c++) run_left[c] = $urandom_range(1, 10);
      for (int i = 0; i < 600; i++) begin
         for (int c = 0; c < CH; c++) begin
            if (run_left[c] == 0) begin
               switch_n[c] = ~switch_n[c];
               run_left[c] = $urandom_range(1, 10);
            end
            run_left[c]--;
         end
         RESET_N = ($urandom_range(0, 149) != 0);
         tick();
         assert_cnt++;
         if (mode !== exp_mode_vec() || mode_al !== exp_mode_vec() ||
             led !== exp_led_vec() || led_al !== ~exp_led_vec()) begin
            fail_cnt++;
            $display("[TB] FAIL random cycle %0d: mode %b led %b led_al %b, want %b %b", i, mode, led, led_al, exp_mode_vec(), exp_led_vec());
         end
      end
      RESET_N = 1'b1;
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_cycling();
      test_simultaneous();
      test_reset_mid_blink();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule
